// File: rtl/posbus_tty_dev.sv
// ============================================================================
//  Module      : posbus_tty_dev
//  Description : Positive-bus console-style I/O device.  Decodes PDP-8/I IOT
//                pulses plus the device-select field of the buffered MB and
//                answers on the open-collector return lines (skip, AC clear,
//                AC data, interrupt request).  The program side is bridged to
//                one byte-wide receive stream and one byte-wide transmit
//                stream (valid/ready).
//
//  Bit numbering: 12-bit bus vectors are declared [11:0].  PDP-8 bit k (bit 0
//                is the MSB) sits at vector index 11-k.  The device code
//                (PDP bits 3..8) is therefore pb_bmb_h[8:3], and AC bits 4..11
//                are index [7:0].
//
//  Ports       : clk, rst              clock, synchronous active-high reset
//                pb_bmb_h, pb_bac_h    buffered MB / AC from the converter
//                pb_iop1/2/4_h         IOT pulses (active-high, multi-cycle)
//                pb_init_h             bus initialize
//                pb_ac_l               AC input lines, active-low (1 = released)
//                pb_skip_l             skip request, active-low
//                pb_ac_clr_cont_l      AC clear, active-low
//                pb_int_rq_l           interrupt request, active-low
//                rx_data/valid/ready   receive stream (device is the sink)
//                tx_data/valid/ready   transmit stream (device is the source)
//
//  Options     : POSBUS_TTY_INT_EN  - when defined, pb_int_rq_l is driven
//                from the registered OR of both flags; otherwise it stays 1.
//
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module posbus_tty_dev #(
    parameter logic [5:0] RX_CODE     = 6'o03,
    parameter logic [5:0] TX_CODE     = 6'o04,
    parameter int         LOCK_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] pb_bmb_h,
    input  logic [11:0] pb_bac_h,
    input  logic        pb_iop1_h,
    input  logic        pb_iop2_h,
    input  logic        pb_iop4_h,
    input  logic        pb_init_h,
    output logic [11:0] pb_ac_l,
    output logic        pb_skip_l,
    output logic        pb_ac_clr_cont_l,
    output logic        pb_int_rq_l,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam logic [7:0] c_lock_load = 8'(LOCK_CYCLES);

    logic       r_iop1_q, r_iop2_q, r_iop4_q;
    logic [7:0] r_rx_buf;
    logic       r_rx_flag;
    logic       r_rx_lock;
    logic [7:0] r_lock_cnt;
    logic [7:0] r_tx_buf;
    logic       r_tx_flag;
    logic       r_tx_valid;

    logic       w_clear;
    logic       w_rx_sel, w_tx_sel;
    logic       w_iop1_rise, w_iop2_rise, w_iop4_rise, w_iop4_fall;
    logic       w_rx_hs, w_tx_hs;
    logic       w_lock_release;
    logic       w_unused;

    // Only the device-code field and AC bits 4..11 matter to this device.
    assign w_unused = &{1'b0, pb_bmb_h[11:9], pb_bmb_h[2:0], pb_bac_h[11:8]};

    assign w_clear  = rst | pb_init_h;
    assign w_rx_sel = (pb_bmb_h[8:3] == RX_CODE);
    assign w_tx_sel = (pb_bmb_h[8:3] == TX_CODE);

    assign w_iop1_rise = pb_iop1_h & ~r_iop1_q;
    assign w_iop2_rise = pb_iop2_h & ~r_iop2_q;
    assign w_iop4_rise = pb_iop4_h & ~r_iop4_q;
    assign w_iop4_fall = ~pb_iop4_h & r_iop4_q;

    assign rx_ready = ~r_rx_flag & ~r_rx_lock;
    assign w_rx_hs  = rx_valid & rx_ready;
    assign w_tx_hs  = r_tx_valid & tx_ready;

    // The lock ends when the program finishes reading (IOP4 fall), starts a
    // new poll (IOP1 rise), or the counter has run down to zero.
    assign w_lock_release = (w_rx_sel & (w_iop4_fall | w_iop1_rise)) |
                            (r_lock_cnt == 8'd0);

    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_iop1_q   <= 1'b0;
            r_iop2_q   <= 1'b0;
            r_iop4_q   <= 1'b0;
            r_rx_buf   <= 8'd0;
            r_rx_flag  <= 1'b0;
            r_rx_lock  <= 1'b0;
            r_lock_cnt <= 8'd0;
            r_tx_buf   <= 8'd0;
            r_tx_flag  <= 1'b0;
            r_tx_valid <= 1'b0;
        end else begin
            r_iop1_q <= pb_iop1_h;
            r_iop2_q <= pb_iop2_h;
            r_iop4_q <= pb_iop4_h;

            // Receive: a byte accepted in the same cycle as the IOP2 rise is
            // captured, then its flag is cleared by IOP2 and it stays locked.
            if (w_rx_hs) begin
                r_rx_buf  <= rx_data;
                r_rx_flag <= 1'b1;
            end
            if (w_rx_sel & w_iop2_rise) begin
                r_rx_flag  <= 1'b0;
                r_rx_lock  <= 1'b1;
                r_lock_cnt <= c_lock_load;
            end else if (r_rx_lock) begin
                if (w_lock_release) begin
                    r_rx_lock  <= 1'b0;
                    r_lock_cnt <= 8'd0;
                end else begin
                    r_lock_cnt <= r_lock_cnt - 8'd1;
                end
            end

            // Transmit: a fresh load overrides everything else this cycle.
            if (w_tx_hs) begin
                r_tx_valid <= 1'b0;
                r_tx_flag  <= 1'b1;
            end
            if (w_tx_sel & w_iop2_rise) begin
                r_tx_flag <= 1'b0;
            end
            if (w_tx_sel & w_iop4_rise) begin
                r_tx_buf   <= pb_bac_h[7:0];
                r_tx_flag  <= 1'b0;
                r_tx_valid <= 1'b1;
            end
        end
    end

    assign tx_data  = r_tx_buf;
    assign tx_valid = r_tx_valid;

    // Bus return lines follow the IOP levels with no clock latency.
    assign pb_skip_l        = ~((w_rx_sel & pb_iop1_h & r_rx_flag) |
                                (w_tx_sel & pb_iop1_h & r_tx_flag));
    assign pb_ac_clr_cont_l = ~(w_rx_sel & pb_iop2_h);
    assign pb_ac_l          = (w_rx_sel & pb_iop4_h) ? {4'hF, ~r_rx_buf}
                                                     : 12'hFFF;

`ifdef POSBUS_TTY_INT_EN
    logic r_int_rq_l;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_int_rq_l <= 1'b1;
        end else begin
            r_int_rq_l <= ~(r_rx_flag | r_tx_flag);
        end
    end

    assign pb_int_rq_l = r_int_rq_l;
`else
    assign pb_int_rq_l = 1'b1;
`endif

endmodule

`default_nettype wire

// File: tb/tb_posbus_tty_dev.sv
// ============================================================================
//  Module      : tb_posbus_tty_dev
//  Description : Directed self-checking bench for posbus_tty_dev.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_posbus_tty_dev;

    localparam int          c_lock   = 64;
    localparam logic [11:0] c_mb_rx  = 12'o6031;   // device code 03
    localparam logic [11:0] c_mb_tx  = 12'o6041;   // device code 04
    localparam logic [11:0] c_mb_oth = 12'o6051;   // device code 05

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] pb_bmb_h, pb_bac_h;
    logic        pb_iop1_h, pb_iop2_h, pb_iop4_h, pb_init_h;
    logic [11:0] pb_ac_l;
    logic        pb_skip_l, pb_ac_clr_cont_l, pb_int_rq_l;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_ready;

    int n_tests = 0;
    int n_fail  = 0;

    posbus_tty_dev #(
        .RX_CODE     (6'o03),
        .TX_CODE     (6'o04),
        .LOCK_CYCLES (c_lock)
    ) u_dut (
        .clk              (clk),
        .rst              (rst),
        .pb_bmb_h         (pb_bmb_h),
        .pb_bac_h         (pb_bac_h),
        .pb_iop1_h        (pb_iop1_h),
        .pb_iop2_h        (pb_iop2_h),
        .pb_iop4_h        (pb_iop4_h),
        .pb_init_h        (pb_init_h),
        .pb_ac_l          (pb_ac_l),
        .pb_skip_l        (pb_skip_l),
        .pb_ac_clr_cont_l (pb_ac_clr_cont_l),
        .pb_int_rq_l      (pb_int_rq_l),
        .rx_data          (rx_data),
        .rx_valid         (rx_valid),
        .rx_ready         (rx_ready),
        .tx_data          (tx_data),
        .tx_valid         (tx_valid),
        .tx_ready         (tx_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance n clocks; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; pb_init_h = 1'b0;
        pb_bmb_h = 12'o0; pb_bac_h = 12'o0;
        pb_iop1_h = 1'b0; pb_iop2_h = 1'b0; pb_iop4_h = 1'b0;
        rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b0;
        tick(2);
        rst = 1'b0;
        check("rst_ac",      32'(pb_ac_l),          32'o7777);
        check("rst_skip",    32'(pb_skip_l),        32'd1);
        check("rst_clr",     32'(pb_ac_clr_cont_l), 32'd1);
        check("rst_int",     32'(pb_int_rq_l),      32'd1);
        check("rst_rxrdy",   32'(rx_ready),         32'd1);
        check("rst_txvalid", 32'(tx_valid),         32'd0);
        check("rst_txdata",  32'(tx_data),          32'h00);

        // ---------------- receive ----------------
        rx_data = 8'h5A; rx_valid = 1'b1;
        tick(1);
        rx_valid = 1'b0;
        check("rx_full_rdy", 32'(rx_ready), 32'd0);
        pb_bmb_h = c_mb_rx; pb_iop1_h = 1'b1; #1;
        check("rx_skip", 32'(pb_skip_l), 32'd0);
        tick(2); pb_iop1_h = 1'b0; tick(1);
        pb_iop2_h = 1'b1; #1;
        check("rx_acclr", 32'(pb_ac_clr_cont_l), 32'd0);
        tick(1); pb_iop2_h = 1'b0; tick(1);
        check("rx_locked_rdy", 32'(rx_ready), 32'd0);
        pb_iop1_h = 1'b1; #1;
        check("rx_noskip_after_iop2", 32'(pb_skip_l), 32'd1);
        pb_iop1_h = 1'b0; tick(1);
        pb_iop4_h = 1'b1; #1;
        check("rx_ac_5a", 32'(pb_ac_l), 32'o7645);
        tick(1); pb_iop4_h = 1'b0; tick(1);
        check("rx_rdy_after_iop4", 32'(rx_ready), 32'd1);

        // ---------------- transmit ----------------
        pb_bmb_h = c_mb_tx; pb_bac_h = 12'o0301; pb_iop4_h = 1'b1;
        #1;
        check("tx_ac_released", 32'(pb_ac_l), 32'o7777);
        tick(1); pb_iop4_h = 1'b0;
        check("tx_data_c1",  32'(tx_data),  32'hC1);
        check("tx_valid_1",  32'(tx_valid), 32'd1);
        tick(5);
        check("tx_hold_valid", 32'(tx_valid), 32'd1);
        check("tx_hold_data",  32'(tx_data),  32'hC1);
        tx_ready = 1'b1; tick(1); tx_ready = 1'b0;
        check("tx_accepted", 32'(tx_valid), 32'd0);
        pb_iop1_h = 1'b1; #1;
        check("tx_skip", 32'(pb_skip_l), 32'd0);
        pb_iop1_h = 1'b0; tick(1);
        pb_iop2_h = 1'b1; #1;
        check("tx_no_acclr", 32'(pb_ac_clr_cont_l), 32'd1);
        tick(1); pb_iop2_h = 1'b0; tick(1);
        pb_iop1_h = 1'b1; #1;
        check("tx_flag_cleared", 32'(pb_skip_l), 32'd1);
        pb_iop1_h = 1'b0; tick(1);
        // overwrite while still valid
        pb_bac_h = 12'o0012; pb_iop4_h = 1'b1; tick(1); pb_iop4_h = 1'b0; tick(1);
        pb_bac_h = 12'o0377; pb_iop4_h = 1'b1; tick(1); pb_iop4_h = 1'b0; tick(1);
        check("tx_overwrite_data",  32'(tx_data),  32'hFF);
        check("tx_overwrite_valid", 32'(tx_valid), 32'd1);
        tx_ready = 1'b1; tick(1); tx_ready = 1'b0;
        check("tx_overwrite_acc", 32'(tx_valid), 32'd0);

        // ---------------- lock released by IOP4 fall ----------------
        pb_bmb_h = c_mb_rx;
        pb_iop2_h = 1'b1; tick(1); pb_iop2_h = 1'b0;
        rx_data = 8'h33; rx_valid = 1'b1;
        tick(3);
        check("lock_blocks", 32'(rx_ready), 32'd0);
        pb_iop4_h = 1'b1; tick(1);
        check("lock_iop4_high", 32'(rx_ready), 32'd0);
        pb_iop4_h = 1'b0; tick(1);
        check("lock_released", 32'(rx_ready), 32'd1);
        tick(1); rx_valid = 1'b0;
        check("lock_accept", 32'(rx_ready), 32'd0);
        pb_iop4_h = 1'b1; #1;
        check("rx_ac_33", 32'(pb_ac_l), 32'o7714);
        tick(1); pb_iop4_h = 1'b0; tick(1);

        // ---------------- lock timeout ----------------
        pb_iop2_h = 1'b1; tick(1); pb_iop2_h = 1'b0;
        rx_data = 8'h44; rx_valid = 1'b1;
        tick(c_lock);
        check("timeout_still_locked", 32'(rx_ready), 32'd0);
        tick(1);
        check("timeout_release", 32'(rx_ready), 32'd1);
        tick(1); rx_valid = 1'b0;
        check("timeout_accept", 32'(rx_ready), 32'd0);

        // ---------------- init mid-transfer ----------------
        pb_bmb_h = c_mb_tx; pb_bac_h = 12'o0125; pb_iop4_h = 1'b1;
        tick(1); pb_iop4_h = 1'b0; tick(1);
        check("init_pre_txvalid", 32'(tx_valid), 32'd1);
        pb_init_h = 1'b1; tick(1); pb_init_h = 1'b0;
        check("init_txvalid", 32'(tx_valid), 32'd0);
        check("init_txdata",  32'(tx_data),  32'h00);
        check("init_rxrdy",   32'(rx_ready), 32'd1);
        pb_bmb_h = c_mb_rx; pb_iop1_h = 1'b1; #1;
        check("init_rxflag", 32'(pb_skip_l), 32'd1);
        pb_bmb_h = c_mb_tx; #1;
        check("init_txflag", 32'(pb_skip_l), 32'd1);
        pb_iop1_h = 1'b0; tick(1);

        // ---------------- deselect / interrupt ----------------
        rx_data = 8'h77; rx_valid = 1'b1; tick(1); rx_valid = 1'b0;
        tick(1);
        pb_bmb_h = c_mb_oth;
        pb_iop1_h = 1'b1; #1;
        check("desel_skip", 32'(pb_skip_l), 32'd1);
        pb_iop1_h = 1'b0; tick(1);
        pb_iop2_h = 1'b1; #1;
        check("desel_acclr", 32'(pb_ac_clr_cont_l), 32'd1);
        tick(1); pb_iop2_h = 1'b0; tick(1);
        pb_iop4_h = 1'b1; #1;
        check("desel_ac", 32'(pb_ac_l), 32'o7777);
        tick(1); pb_iop4_h = 1'b0; tick(1);
        check("desel_flag_kept", 32'(rx_ready), 32'd0);
`ifdef POSBUS_TTY_INT_EN
        check("int_asserted", 32'(pb_int_rq_l), 32'd0);
`else
        check("int_idle", 32'(pb_int_rq_l), 32'd1);
`endif
        pb_bmb_h = c_mb_rx; pb_iop2_h = 1'b1; tick(1); pb_iop2_h = 1'b0; tick(1);
        check("int_cleared", 32'(pb_int_rq_l), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/posbus_tty_dev.md
# posbus_tty_dev

Positive-bus console-style I/O device that terminates the far end of the negative-to-positive bus converter. It decodes IOT pulses and the device-select bits from the buffered MB, and answers on the open-collector return lines: skip, AC clear, AC data and interrupt request. It bridges the PDP-8/I program-controlled I/O protocol to a pair of byte-wide valid/ready streams, one receive and one transmit, on the FPGA side.

## Interface
Parameters:
- RX_CODE, 6'o03, device code for the receive side (KRS/KCC/KRB-style IOTs).
- TX_CODE, 6'o04, device code for the transmit side (TSF/TCF/TLS-style IOTs).
- LOCK_CYCLES, 64, timeout in clocks for the receive-buffer lock; 8-bit counter, legal range 1..255.

Ports (clock and reset first):
- clk  in  1  system clock; all bus inputs are already synchronous to clk.
- rst  in  1  reset, synchronous and active-high.
- pb_bmb_h  in  12  buffered MB; bit k = PDP-8 bit k (bit 0 MSB); device code = pb_bmb_h[3:8], bit 3 MSB.
- pb_bac_h  in  12  buffered AC; transmit data is in AC bits 4..11.
- pb_iop1_h / pb_iop2_h / pb_iop4_h  in  1 each  IOT pulses, active-high, multi-cycle.
- pb_init_h  in  1  bus initialize, active-high.
- pb_ac_l  out  12  AC input lines, active-low OC; 1 = released.
- pb_skip_l  out  1  skip request, active-low.
- pb_ac_clr_cont_l  out  1  AC clear, active-low.
- pb_int_rq_l  out  1  interrupt request, active-low.
- rx_data  in  8  receive byte; rx_valid in 1; rx_ready out 1.
- tx_data  out  8  transmit byte; tx_valid out 1; tx_ready in 1.

## Operation
- Selected: rx_sel = (pb_bmb_h[3:8] == RX_CODE); tx_sel = (pb_bmb_h[3:8] == TX_CODE).
- IOP edges: a registered copy of each IOP gives rise = iop & ~iop_q and fall = ~iop & iop_q. State changes happen only on edges.
- Receive state: rx_buf[7:0], rx_flag, rx_lock, lock_cnt.
  - rx_ready = ~rx_flag & ~rx_lock.
  - When rx_valid & rx_ready: rx_buf <= rx_data and rx_flag <= 1.
  - rx_sel & IOP2 rise: rx_flag <= 0, rx_lock <= 1, lock_cnt <= LOCK_CYCLES.
  - rx_lock clears on any of: rx_sel & IOP4 fall; rx_sel & IOP1 rise; lock_cnt reaching 0 (decrements each clock while locked); init.
- Transmit state: tx_buf[7:0], tx_flag, tx_valid.
  - tx_sel & IOP4 rise: tx_buf <= {pb_bac_h[4],...,pb_bac_h[11]} (AC bit 4 → tx_data[7]), tx_flag <= 0, tx_valid <= 1.
  - IOP4 rise while tx_valid is already 1: the new byte overwrites tx_buf and tx_valid stays 1. The previous byte is lost; this is the program's error.
  - tx_valid & tx_ready: tx_valid <= 0, tx_flag <= 1.
  - tx_sel & IOP2 rise: tx_flag <= 0.
- Bus drives. These are combinational from the current IOP level, the select bits and the state registers. Every line not listed is released (1).
  - pb_skip_l = ~((rx_sel & iop1 & rx_flag) | (tx_sel & iop1 & tx_flag)).
  - pb_ac_clr_cont_l = ~(rx_sel & iop2).
  - pb_ac_l: during rx_sel & iop4, pb_ac_l[4+i] = ~rx_buf[7-i] for i = 0..7 and bits 0..3 = 1; otherwise all 1.
- Init/reset. rst, or pb_init_h high, clears rx_buf, tx_buf, both flags, rx_lock, lock_cnt, tx_valid and the IOP history registers. Init has priority over all same-cycle events.
- Simultaneous rx handshake and IOP2 rise: the handshake cannot occur in that cycle, because the flag was set so rx_ready = 0. If rx_flag = 0 and rx_lock = 0, the handshake wins and IOP2 then clears the new flag. The new byte is locked and stays readable by IOP4.

## Timing
- Reset values: pb_ac_l = 12'o7777; pb_skip_l, pb_ac_clr_cont_l and pb_int_rq_l = 1; rx_ready = 1; tx_valid = 0; tx_data = 0.
- Bus return lines follow IOP levels with zero clock latency. Flag, buffer and lock updates take effect one clock after the rising (or falling) edge is sampled.
- Stream handshakes complete in the clock where valid & ready are both high. tx_valid holds, and tx_data is stable, until accepted.
- Lock timeout: rx_ready reasserts LOCK_CYCLES+1 clocks after the IOP2 rise if no release event occurs first.

## Configuration
- POSBUS_TTY_INT_EN defined: pb_int_rq_l = ~(rx_flag | tx_flag), updated one clock after a flag change.
- Not defined: pb_int_rq_l is constant 1, and the device is skip-polled only.

## Test plan
- Reset: pulse rst for 2 clocks → pb_ac_l = 12'o7777, all other return lines 1, rx_ready = 1, tx_valid = 0.
- Receive: rx_data = 8'h5A handshake; IOP1 with code 03 → pb_skip_l = 0 and rx_ready = 0; IOP2 → pb_ac_clr_cont_l = 0 and rx_flag clear; IOP4 → pb_ac_l = 12'o7645.
- Transmit: IOP4 with code 04 and pb_bac_h = 12'o0301 → tx_data = 8'hC1, tx_valid = 1; hold tx_ready = 0 for 5 clocks → no change; tx_ready = 1 → tx_valid = 0 next clock; IOP1 code 04 → pb_skip_l = 0.
- Lock: IOP2 on code 03 then rx_valid with 8'h33 → not accepted until the IOP4 fall. Repeat with no IOP4 → accepted after LOCK_CYCLES+1 clocks.
- Init mid-transfer: tx_valid = 1 and rx_flag = 1, then pb_init_h for 1 clock → both flags 0, tx_valid = 0, rx_ready = 1.
- Deselect/interrupt: IOPs with code 05 → no line driven. With POSBUS_TTY_INT_EN, receiving a byte → pb_int_rq_l = 0 until IOP2 on code 03.
